// File: rtl/seg_scan_driver.sv
// seg_scan_driver: converts an 8-bit magnitude plus sign into three BCD digits
// with a sequential double-dabble FSM, then time-multiplexes the digits onto a
// 3-digit common-cathode-bus seven-segment display.
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   value   unsigned magnitude 0..255
//   is_neg  result is negative (value holds the magnitude)
//   valid   one-cycle strobe sampling value/is_neg
//   busy    high while a conversion is shifting
//   out     cathodes {g,f,e,d,c,b,a}, active-low
//   invAn   anodes, active-low; bit0 = ones digit (rightmost)
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       is_neg,
    input  logic       valid,
    output logic       busy,
    output logic [6:0] out,
    output logic [2:0] invAn
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegMinus = 7'b0111111;

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = SegBlank;
        endcase
    endfunction

    // One double-dabble step: {hundreds, tens, ones, binary} adjust then shift.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] a;
        a = s;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       iter_q, iter_d;
    logic [19:0]      sh_q, sh_d;
    logic             neg_q, neg_d;
    logic             pend_q, pend_d;
    logic [7:0]       pend_val_q, pend_val_d;
    logic             pend_neg_q, pend_neg_d;
    logic [6:0]       dig0_q, dig0_d, dig1_q, dig1_d, dig2_q, dig2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [6:0]       out_q, out_d;
    logic [2:0]       an_q, an_d;
    logic [3:0]       bcd_h, bcd_t, bcd_o;
    logic             wrap;

    assign bcd_h = sh_q[19:16];
    assign bcd_t = sh_q[15:12];
    assign bcd_o = sh_q[11:8];

    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        sh_d       = sh_q;
        neg_d      = neg_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        pend_neg_d = pend_neg_q;
        dig0_d     = dig0_q;
        dig1_d     = dig1_q;
        dig2_d     = dig2_q;

        unique case (state_q)
            StIdle: begin
                // A fresh strobe beats a stale pending entry (last wins).
                if (valid) begin
                    sh_d    = {12'b0, value};
                    neg_d   = is_neg;
                    pend_d  = 1'b0;
                    iter_d  = 4'd0;
                    state_d = StShift;
                end else if (pend_q) begin
                    sh_d    = {12'b0, pend_val_q};
                    neg_d   = pend_neg_q;
                    pend_d  = 1'b0;
                    iter_d  = 4'd0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (iter_q == 4'd8) begin
                    state_d = StCommit;
                end else begin
                    sh_d   = dd_step(sh_q);
                    iter_d = iter_q + 4'd1;
                end
            end
            StCommit: begin
                if (neg_q && bcd_h != 4'd0) begin
                    // Negative magnitude >= 100 does not fit: show overflow.
                    dig2_d = SegMinus;
                    dig1_d = SegMinus;
                    dig0_d = SegMinus;
                end else if (neg_q && (bcd_t != 4'd0 || bcd_o != 4'd0)) begin
                    dig2_d = SegMinus;
                    dig1_d = (bcd_t == 4'd0) ? SegBlank : glyph(bcd_t);
                    dig0_d = glyph(bcd_o);
                end else begin
                    // Positive, or negative zero which shows as plain 0.
                    dig2_d = (bcd_h == 4'd0) ? SegBlank : glyph(bcd_h);
                    dig1_d = (bcd_h == 4'd0 && bcd_t == 4'd0) ? SegBlank : glyph(bcd_t);
                    dig0_d = glyph(bcd_o);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (valid && state_q != StIdle) begin
            pend_d     = 1'b1;
            pend_val_d = value;
            pend_neg_d = is_neg;
        end
    end

    // Free-running scan, independent of the conversion FSM.
    always_comb begin
        wrap  = (cnt_q == CntMax);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        sel_d = sel_q;
        if (wrap) sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
        an_d = ~(3'b001 << sel_d);
        // Use next-state digits so a commit reaches the pins on the same edge.
        case (sel_d)
            2'd0:    out_d = dig0_d;
            2'd1:    out_d = dig1_d;
            2'd2:    out_d = dig2_d;
            default: out_d = SegBlank;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            iter_q     <= 4'd0;
            sh_q       <= 20'd0;
            neg_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= 8'd0;
            pend_neg_q <= 1'b0;
            dig0_q     <= SegBlank;
            dig1_q     <= SegBlank;
            dig2_q     <= SegBlank;
            cnt_q      <= '0;
            sel_q      <= 2'd0;
            out_q      <= SegBlank;
            an_q       <= 3'b110;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            sh_q       <= sh_d;
            neg_q      <= neg_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            pend_neg_q <= pend_neg_d;
            dig0_q     <= dig0_d;
            dig1_q     <= dig1_d;
            dig2_q     <= dig2_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            out_q      <= out_d;
            an_q       <= an_d;
        end
    end

    assign busy  = (state_q == StShift);
    assign out   = out_q;
    assign invAn = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: stimulus pushes the expected
// {digit2, digit1, digit0} glyphs when it strobes a value; the monitor pops an
// entry when it sees a commit and checks each digit as the scan exposes it.
module tb_seg_scan_driver;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] GM = 7'b0111111;
    localparam logic [6:0] GB = 7'b1111111;

    logic       clk;
    logic       rst;
    logic [7:0] value;
    logic       is_neg;
    logic       valid;
    logic       busy;
    logic [6:0] out;
    logic [2:0] invAn;

    int n_cmp = 0;
    int n_bad = 0;
    logic [20:0] exp_q[$];

    seg_scan_driver #(.REFRESH_DIV(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .value  (value),
        .is_neg (is_neg),
        .valid  (valid),
        .busy   (busy),
        .out    (out),
        .invAn  (invAn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Called at a negedge; valid is high across exactly one rising edge.
    task automatic pulse(input logic [7:0] v, input logic n);
        value  = v;
        is_neg = n;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
    endtask

    task automatic single(input logic [7:0] v, input logic n, input logic [20:0] e);
        exp_q.push_back(e);
        pulse(v, n);
        repeat (40) @(negedge clk);
    endtask

    // Monitor: busy falling without reset means the next edge commits.
    initial begin : monitor
        logic        prev_busy;
        logic        commit_next;
        logic        active;
        logic [20:0] cur;
        logic [2:0]  done;
        int          idx;
        prev_busy   = 1'b0;
        commit_next = 1'b0;
        active      = 1'b0;
        cur         = '0;
        done        = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_busy   = 1'b0;
                commit_next = 1'b0;
                active      = 1'b0;
            end else begin
                if (commit_next) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_commit: got a commit, expected none");
                    end else begin
                        cur    = exp_q.pop_front();
                        active = 1'b1;
                        done   = '0;
                    end
                end
                if (active) begin
                    case (invAn)
                        3'b110:  idx = 0;
                        3'b101:  idx = 1;
                        3'b011:  idx = 2;
                        default: idx = -1;
                    endcase
                    if (idx < 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL anode_onehot: got %b expected exactly one low bit", invAn);
                        active = 1'b0;
                    end else if (!done[idx]) begin
                        chk($sformatf("digit%0d", idx), {25'd0, out}, {25'd0, cur[idx*7 +: 7]});
                        done[idx] = 1'b1;
                    end
                    if (done == 3'b111) active = 1'b0;
                end
                commit_next = prev_busy && !busy;
                prev_busy   = busy;
            end
        end
    end

    initial begin : stimulus
        logic ok;
        rst    = 1'b1;
        valid  = 1'b0;
        value  = 8'd0;
        is_neg = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out", {25'd0, out}, {25'd0, GB});
        chk("reset_an", {29'd0, invAn}, 32'b110);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Anode rotation: 8 edges per digit.
        repeat (7) @(negedge clk);
        chk("scan_an_7", {29'd0, invAn}, 32'b110);
        @(negedge clk);
        chk("scan_an_8", {29'd0, invAn}, 32'b101);
        repeat (8) @(negedge clk);
        chk("scan_an_16", {29'd0, invAn}, 32'b011);
        repeat (8) @(negedge clk);
        chk("scan_an_24", {29'd0, invAn}, 32'b110);
        chk("scan_out_blank", {25'd0, out}, {25'd0, GB});

        // 25: busy high for exactly nine cycles after the strobe edge.
        exp_q.push_back({GB, G2, G5});
        pulse(8'd25, 1'b0);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("busy_high_%0d", i), {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        chk("busy_low_after", {31'd0, busy}, 32'd0);
        repeat (30) @(negedge clk);

        single(8'd225, 1'b0, {G2, G2, G5});
        single(8'd0,   1'b0, {GB, GB, G0});
        single(8'd105, 1'b0, {G1, G0, G5});
        single(8'd255, 1'b0, {G2, G5, G5});
        single(8'd2,   1'b1, {GM, GB, G2});
        single(8'd100, 1'b1, {GM, GM, GM});
        single(8'd45,  1'b1, {GM, G4, G5});
        single(8'd0,   1'b1, {GB, GB, G0});

        // Back-to-back: 10 at N, 8 at N+3, 64 at N+5; 8 is overwritten.
        exp_q.push_back({GB, G1, G0});
        pulse(8'd10, 1'b0);
        repeat (2) @(negedge clk);
        pulse(8'd8, 1'b0);
        @(negedge clk);
        exp_q.push_back({GB, G6, G4});
        pulse(8'd64, 1'b0);
        repeat (45) @(negedge clk);

        // Reset mid-conversion of 99 with 55 pending: nothing must commit.
        pulse(8'd99, 1'b0);
        @(negedge clk);
        pulse(8'd55, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_out", {25'd0, out}, {25'd0, GB});
        chk("midrst_an", {29'd0, invAn}, 32'b110);
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (out !== GB) ok = 1'b0;
        end
        chk("midrst_stays_blank", {31'd0, ok}, 32'd1);

        repeat (20) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
